// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: intersection sequencer that loads and starts the seconds timer,
// drives both streets' lights and the WALK lamp, and serves the sensor and walk button.
`default_nettype none

module traffic_light_ctrl #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_btn,
    input  logic       expired,
    output logic       start_timer,
    output logic [4:0] value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        MG   = 3'd0,
        MY   = 3'd1,
        SG   = 3'd2,
        SGX  = 3'd3,
        SY   = 3'd4,
        WALK = 3'd5
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       go;
    logic [4:0] next_value;
    logic       set_ext;
    logic       clr_ext;
    logic [2:0] next_main;
    logic [2:0] next_side;
    logic       next_walk;
    logic       walk_pending;
    logic       ext_used;
    logic       armed;
    logic       arm_pre;
    logic       fresh;

    // Expiry is honoured only once armed, i.e. two cycles after the start pulse.
    always_comb begin
        go         = 1'b0;
        next_state = state;
        next_value = value;
        set_ext    = 1'b0;
        clr_ext    = 1'b0;
        if (fresh) begin
            go         = 1'b1;
            next_state = MG;
            next_value = 5'(T_BASE);
        end else if (armed && expired) begin
            go = 1'b1;
            case (state)
                MG: begin
                    if (sensor || walk_pending) begin
                        next_state = MY;
                        next_value = 5'(T_YEL);
                    end else begin
                        next_state = MG;
                        next_value = 5'(T_BASE);
                    end
                end
                MY: begin
                    next_state = SG;
                    next_value = 5'(T_BASE);
                    clr_ext    = 1'b1;
                end
                SG: begin
                    if (sensor && !ext_used) begin
                        next_state = SGX;
                        next_value = 5'(T_EXT);
                        set_ext    = 1'b1;
                    end else begin
                        next_state = SY;
                        next_value = 5'(T_YEL);
                    end
                end
                SGX: begin
                    next_state = SY;
                    next_value = 5'(T_YEL);
                end
                SY: begin
                    if (walk_pending) begin
                        next_state = WALK;
                        next_value = 5'(T_WALK);
                    end else begin
                        next_state = MG;
                        next_value = 5'(T_BASE);
                    end
                end
                default: begin
                    next_state = MG;
                    next_value = 5'(T_BASE);
                end
            endcase
        end
    end

    always_comb begin
        next_main = 3'b100;
        next_side = 3'b100;
        next_walk = 1'b0;
        case (next_state)
            MG:      next_main = 3'b001;
            MY:      next_main = 3'b010;
            SG, SGX: next_side = 3'b001;
            SY:      next_side = 3'b010;
            WALK:    next_walk = 1'b1;
            default: next_main = 3'b100;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= MG;
            main_light   <= 3'b001;
            side_light   <= 3'b100;
            walk         <= 1'b0;
            start_timer  <= 1'b0;
            value        <= 5'd0;
            walk_pending <= 1'b0;
            ext_used     <= 1'b0;
            armed        <= 1'b0;
            arm_pre      <= 1'b0;
            fresh        <= 1'b1;
        end else begin
            fresh       <= 1'b0;
            start_timer <= go;
            if (go) begin
                state      <= next_state;
                value      <= next_value;
                main_light <= next_main;
                side_light <= next_side;
                walk       <= next_walk;
                armed      <= 1'b0;
                arm_pre    <= 1'b0;
            end else begin
                arm_pre <= start_timer;
                armed   <= armed | arm_pre;
            end
            // Entering WALK consumes the request; a press in that same cycle is absorbed.
            if (go && next_state == WALK)
                walk_pending <= 1'b0;
            else if (walk_btn)
                walk_pending <= 1'b1;
            if (set_ext)
                ext_used <= 1'b1;
            else if (clr_ext)
                ext_used <= 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of the light sequencer against a simple
// cycle-counting timer model (one cycle per second).
`default_nettype none

module tb_traffic_light_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_btn = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [4:0] value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state_dbg;

    logic       manual = 1'b0;
    logic       man_exp = 1'b0;
    logic       tflag = 1'b0;
    logic [4:0] cnt = 5'd0;
    logic       live = 1'b0;

    int checks = 0;
    int failures = 0;

    traffic_light_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .sensor      (sensor),
        .walk_btn    (walk_btn),
        .expired     (expired),
        .start_timer (start_timer),
        .value       (value),
        .main_light  (main_light),
        .side_light  (side_light),
        .walk        (walk),
        .state_dbg   (state_dbg)
    );

    always #5 clock = ~clock;

    // Timer model: loads on start, flag clears one cycle after start, rises after value cycles.
    always @(posedge clock) begin
        if (start_timer) begin
            cnt   <= value;
            tflag <= 1'b0;
        end else if (cnt > 5'd1) begin
            cnt <= cnt - 5'd1;
        end else if (cnt == 5'd1) begin
            cnt   <= 5'd0;
            tflag <= 1'b1;
        end
    end

    assign expired = manual ? man_exp : tflag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cycle: one lamp per street, and at least one street red.
    always @(negedge clock) begin
        if (live) begin
            check("safety",
                  {32'($onehot(main_light)), 32'($onehot(side_light))} == 64'h1_00000001 &&
                  (main_light == 3'b100 || side_light == 3'b100), 1);
        end
    end

    task automatic expect_phase(input string tag, input int budget, input logic [2:0] st,
                                input logic [4:0] val, input logic [2:0] m,
                                input logic [2:0] s, input logic w);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!start_timer && n < budget);
        check({tag, "_start"}, start_timer, 1);
        check({tag, "_state"}, state_dbg, st);
        check({tag, "_value"}, value, val);
        check({tag, "_main"}, main_light, m);
        check({tag, "_side"}, side_light, s);
        check({tag, "_walk"}, walk, w);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press();
        walk_btn = 1'b1;
        tick(1);
        walk_btn = 1'b0;
    endtask

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam int BUD = 40;

    initial begin
        // Reset values
        tick(3);
        check("rst_state", state_dbg, 0);
        check("rst_main", main_light, G);
        check("rst_side", side_light, R);
        check("rst_walk", walk, 0);
        check("rst_start", start_timer, 0);
        check("rst_value", value, 0);
        live  = 1'b1;
        reset = 1'b0;

        // Fresh start one cycle after reset, then idle MG restarts
        expect_phase("fresh", 1, 0, 6, G, R, 0);
        tick(1);
        check("fresh_pulse_end", start_timer, 0);
        expect_phase("mg_restart1", BUD, 0, 6, G, R, 0);
        expect_phase("mg_restart2", BUD, 0, 6, G, R, 0);

        // Sensor held: full side cycle with one extension
        sensor = 1'b1;
        expect_phase("s_my", BUD, 1, 2, Y, R, 0);
        expect_phase("s_sg", BUD, 2, 6, R, G, 0);
        expect_phase("s_sgx", BUD, 3, 3, R, G, 0);
        expect_phase("s_sy", BUD, 4, 2, R, Y, 0);
        expect_phase("s_mg", BUD, 0, 6, G, R, 0);
        expect_phase("s_my2", BUD, 1, 2, Y, R, 0);
        expect_phase("s_sg2", BUD, 2, 6, R, G, 0);
        expect_phase("s_sgx2", BUD, 3, 3, R, G, 0);
        sensor = 1'b0;
        expect_phase("s_sy2", BUD, 4, 2, R, Y, 0);
        expect_phase("s_mg2", BUD, 0, 6, G, R, 0);
        expect_phase("s_mg_idle", BUD, 0, 6, G, R, 0);

        // Walk press during SG, sensor off
        sensor = 1'b1;
        expect_phase("w_my", BUD, 1, 2, Y, R, 0);
        sensor = 1'b0;
        expect_phase("w_sg", BUD, 2, 6, R, G, 0);
        press();
        expect_phase("w_sy", BUD, 4, 2, R, Y, 0);
        expect_phase("w_walk", BUD, 5, 5, R, R, 1);
        expect_phase("w_mg", BUD, 0, 6, G, R, 0);
        expect_phase("w_mg_idle", BUD, 0, 6, G, R, 0);

        // Press in the exact cycle SY->WALK fires is absorbed
        sensor = 1'b1;
        expect_phase("a_my", BUD, 1, 2, Y, R, 0);
        sensor = 1'b0;
        expect_phase("a_sg", BUD, 2, 6, R, G, 0);
        press();
        expect_phase("a_sy", BUD, 4, 2, R, Y, 0);
        tick(3);
        walk_btn = 1'b1;
        tick(1);
        walk_btn = 1'b0;
        check("a_walk_edge_start", start_timer, 1);
        check("a_walk_edge_state", state_dbg, 5);
        expect_phase("a_mg", BUD, 0, 6, G, R, 0);
        sensor = 1'b1;
        expect_phase("a_my2", BUD, 1, 2, Y, R, 0);
        sensor = 1'b0;
        expect_phase("a_sg2", BUD, 2, 6, R, G, 0);
        expect_phase("a_sy2", BUD, 4, 2, R, Y, 0);
        expect_phase("a_mg_not_walk", BUD, 0, 6, G, R, 0);

        // Press during MG, then a second press during WALK
        press();
        expect_phase("p_my", BUD, 1, 2, Y, R, 0);
        expect_phase("p_sg", BUD, 2, 6, R, G, 0);
        expect_phase("p_sy", BUD, 4, 2, R, Y, 0);
        expect_phase("p_walk", BUD, 5, 5, R, R, 1);
        tick(1);
        press();
        expect_phase("p_mg", BUD, 0, 6, G, R, 0);
        expect_phase("p_my2", BUD, 1, 2, Y, R, 0);
        expect_phase("p_sg2", BUD, 2, 6, R, G, 0);
        expect_phase("p_sy2", BUD, 4, 2, R, Y, 0);
        expect_phase("p_walk2", BUD, 5, 5, R, R, 1);
        expect_phase("p_mg2", BUD, 0, 6, G, R, 0);

        // expired held high: transitions only every third edge
        manual  = 1'b1;
        man_exp = 1'b1;
        sensor  = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            logic [2:0] es;
            tick(1);
            es = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : (k < 9) ? 3'd2 :
                 (k < 12) ? 3'd3 : (k < 15) ? 3'd4 : 3'd0;
            check($sformatf("hold_state_k%0d", k), state_dbg, es);
            check($sformatf("hold_start_k%0d", k), start_timer, (k % 3) == 0);
        end
        manual  = 1'b0;
        man_exp = 1'b0;

        // Reset while in SGX
        expect_phase("r_my", BUD, 1, 2, Y, R, 0);
        expect_phase("r_sg", BUD, 2, 6, R, G, 0);
        expect_phase("r_sgx", BUD, 3, 3, R, G, 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sensor = 1'b0;
        check("r_state", state_dbg, 0);
        check("r_main", main_light, G);
        check("r_side", side_light, R);
        check("r_walk", walk, 0);
        check("r_start", start_timer, 0);
        check("r_value", value, 0);
        expect_phase("r_fresh", 1, 0, 6, G, R, 0);
        tick(1);
        check("r_pulse_end", start_timer, 0);
        expect_phase("r_mg_idle", BUD, 0, 6, G, R, 0);

        live = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
